// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: single-entry issue register with busy-vector hazard check, outstanding-write limit and branch wait
module fu_issue_scheduler #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid_i,
  output logic       dec_ready_o,
  input  logic [2:0] dec_fu_i,
  input  logic [4:0] dec_rs1_i,
  input  logic [4:0] dec_rs2_i,
  input  logic [4:0] dec_rd_i,
  input  logic       dec_use_rs2_i,
  input  logic       dec_we_i,
  input  logic       alu_ready_i,
  input  logic       mult_ready_i,
  input  logic       lsu_ready_i,
  input  logic       csr_ready_i,
  output logic       iss_valid_o,
  output logic [2:0] iss_fu_o,
  output logic [4:0] iss_rd_o,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_rd_i,
  input  logic       resolve_valid_i,
  input  logic       flush_i
);
  typedef enum logic {RUN, BR_WAIT} state_t;
  state_t state_q, state_d;
  logic [31:0] busy, busy_d, wb_clr, busy_eff;
  logic [2:0] count, count_d;
  logic hazard, tgt_ready, fire, accept, real_fu, inc, dec;
  always_comb begin
    wb_clr = wb_valid_i ? 32'(1) << wb_rd_i : '0;
    busy_eff = busy & ~wb_clr;
    hazard = busy_eff[dec_rs1_i] | (dec_use_rs2_i & busy_eff[dec_rs2_i]) | (dec_we_i & busy_eff[dec_rd_i]);
    tgt_ready = (iss_fu_o == 3'd3 || iss_fu_o == 3'd4) ? alu_ready_i :
                iss_fu_o == 3'd5 ? mult_ready_i :
                (iss_fu_o == 3'd1 || iss_fu_o == 3'd2) ? lsu_ready_i :
                iss_fu_o == 3'd6 ? csr_ready_i : 1'b0;
    fire = iss_valid_o & tgt_ready;
    dec_ready_o = !reset && state_q == RUN && !flush_i && !hazard &&
                  (int'(count) < MAX_OUTSTANDING || !dec_we_i) && (!iss_valid_o || fire);
    accept = dec_valid_i & dec_ready_o;
    real_fu = dec_fu_i != 3'd0 && dec_fu_i != 3'd7;
    inc = accept & real_fu & dec_we_i & (dec_rd_i != 5'd0);
    dec = wb_valid_i & busy[wb_rd_i];
    busy_d = (busy_eff | (inc ? 32'(1) << dec_rd_i : '0)) & ~32'd1;
    count_d = count + {2'b0, inc} - {2'b0, dec};
    state_d = flush_i ? RUN :
              (state_q == RUN && accept && dec_fu_i == 3'd4) ? BR_WAIT :
              (state_q == BR_WAIT && resolve_valid_i) ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      busy <= '0;
      count <= '0;
      iss_valid_o <= 1'b0;
      iss_fu_o <= '0;
      iss_rd_o <= '0;
    end else begin
      state_q <= state_d;
      busy <= busy_d;
      count <= count_d;
      iss_valid_o <= !flush_i && ((accept && real_fu) || (iss_valid_o && !fire));
      if (accept && real_fu) begin
        iss_fu_o <= dec_fu_i;
        iss_rd_o <= dec_rd_i;
      end
    end
  end
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: directed scenarios plus random traffic checked against a behavioural model
module tb_fu_issue_scheduler;
  localparam int MAX = 4;
  logic clk = 0, reset = 1;
  logic dec_valid_i = 0, dec_ready_o, dec_use_rs2_i = 0, dec_we_i = 0;
  logic [2:0] dec_fu_i = 0, iss_fu_o;
  logic [4:0] dec_rs1_i = 0, dec_rs2_i = 0, dec_rd_i = 0, iss_rd_o, wb_rd_i = 0;
  logic alu_ready_i = 1, mult_ready_i = 1, lsu_ready_i = 1, csr_ready_i = 1;
  logic iss_valid_o, wb_valid_i = 0, resolve_valid_i = 0, flush_i = 0;
  int n_cmp = 0, n_err = 0;
  bit mb[32];
  int mcnt;
  bit mbr, mv;
  logic [2:0] mfu;
  logic [4:0] mrd;
  fu_issue_scheduler #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset), .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_fu_i(dec_fu_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .dec_use_rs2_i(dec_use_rs2_i), .dec_we_i(dec_we_i), .alu_ready_i(alu_ready_i),
    .mult_ready_i(mult_ready_i), .lsu_ready_i(lsu_ready_i), .csr_ready_i(csr_ready_i),
    .iss_valid_o(iss_valid_o), .iss_fu_o(iss_fu_o), .iss_rd_o(iss_rd_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .resolve_valid_i(resolve_valid_i), .flush_i(flush_i)
  );
  initial forever #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit eff(input logic [4:0] r);
    return mb[r] && !(wb_valid_i && wb_rd_i == r);
  endfunction
  function automatic bit tgt(input logic [2:0] f);
    case (f)
      3'd3, 3'd4: return alu_ready_i;
      3'd5: return mult_ready_i;
      3'd1, 3'd2: return lsu_ready_i;
      3'd6: return csr_ready_i;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [31:0] mbusy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mb[i];
    return v;
  endfunction
  task automatic cycle(input int exp_rdy = -1);
    bit rdy, fire, acc, realc;
    #1;
    fire = mv && tgt(mfu);
    rdy = !reset && !mbr && !flush_i &&
          !(eff(dec_rs1_i) || (dec_use_rs2_i && eff(dec_rs2_i)) || (dec_we_i && eff(dec_rd_i))) &&
          (mcnt < MAX || !dec_we_i) && (!mv || fire);
    check("dec_ready", 32'(dec_ready_o), 32'(rdy));
    if (exp_rdy >= 0) check("dec_ready_directed", 32'(dec_ready_o), 32'(exp_rdy));
    check("iss_valid", 32'(iss_valid_o), 32'(mv));
    if (mv) begin
      check("iss_fu", 32'(iss_fu_o), 32'(mfu));
      check("iss_rd", 32'(iss_rd_o), 32'(mrd));
    end
    check("busy", dut.busy, mbusy());
    check("count", 32'(dut.count), 32'(mcnt));
    if (reset) begin
      foreach (mb[i]) mb[i] = 0;
      mcnt = 0; mbr = 0; mv = 0; mfu = 0; mrd = 0;
    end else begin
      acc = dec_valid_i && rdy;
      realc = dec_fu_i != 0 && dec_fu_i != 7;
      if (wb_valid_i && mb[wb_rd_i]) begin
        mb[wb_rd_i] = 0;
        mcnt--;
      end
      if (acc && realc && dec_we_i && dec_rd_i != 0) begin
        mb[dec_rd_i] = 1;
        mcnt++;
      end
      if (flush_i) mv = 0;
      else if (acc && realc) begin
        mv = 1; mfu = dec_fu_i; mrd = dec_rd_i;
      end else if (fire) mv = 0;
      if (flush_i) mbr = 0;
      else if (mbr && resolve_valid_i) mbr = 0;
      else if (!mbr && acc && dec_fu_i == 3'd4) mbr = 1;
    end
    @(negedge clk);
  endtask
  task automatic set_dec(input logic v, input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u2, input logic we);
    dec_valid_i = v; dec_fu_i = f; dec_rd_i = rd; dec_rs1_i = rs1;
    dec_rs2_i = rs2; dec_use_rs2_i = u2; dec_we_i = we;
  endtask
  initial begin
    @(negedge clk);
    cycle(0);
    cycle(0);
    reset = 0;
    set_dec(1, 3, 5, 1, 2, 1, 1);
    cycle(1);
    set_dec(1, 3, 6, 5, 3, 1, 1);
    cycle(0);
    cycle(0);
    wb_valid_i = 1; wb_rd_i = 5;
    cycle(1);
    dec_valid_i = 0; wb_rd_i = 6;
    cycle();
    wb_valid_i = 0;
    for (int i = 1; i <= 4; i++) begin
      set_dec(1, 1, 5'(i), 0, 0, 0, 1);
      cycle(1);
    end
    check("count_at_limit", 32'(dut.count), 32'd4);
    set_dec(1, 1, 7, 0, 0, 0, 1);
    cycle(0);
    set_dec(1, 3, 0, 0, 0, 0, 0);
    cycle(1);
    dec_valid_i = 0; wb_valid_i = 1;
    for (int i = 1; i <= 4; i++) begin
      wb_rd_i = 5'(i);
      cycle();
    end
    wb_valid_i = 0;
    set_dec(1, 3, 9, 0, 0, 0, 1);
    cycle(1);
    wb_valid_i = 1; wb_rd_i = 9;
    cycle(1);
    wb_valid_i = 0; dec_valid_i = 0;
    cycle();
    check("busy9_set_wins", 32'(dut.busy[9]), 32'd1);
    check("count_set_clear", 32'(dut.count), 32'd1);
    wb_valid_i = 1;
    cycle();
    wb_valid_i = 0;
    set_dec(1, 4, 0, 0, 0, 0, 0);
    cycle(1);
    set_dec(1, 3, 0, 0, 0, 0, 0);
    cycle(0); cycle(0); cycle(0);
    resolve_valid_i = 1;
    cycle(0);
    resolve_valid_i = 0;
    cycle(1);
    dec_valid_i = 0;
    cycle();
    mult_ready_i = 0;
    set_dec(1, 5, 12, 0, 0, 0, 1);
    cycle(1);
    dec_valid_i = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("mult_held_valid", 32'(iss_valid_o), 32'd1);
    check("mult_held_rd", 32'(iss_rd_o), 32'd12);
    flush_i = 1;
    cycle(0);
    flush_i = 0;
    cycle();
    check("flush_empties", 32'(iss_valid_o), 32'd0);
    check("flush_keeps_busy", 32'(dut.busy[12]), 32'd1);
    mult_ready_i = 1;
    for (int i = 13; i <= 15; i++) begin
      set_dec(1, 3, 5'(i), 0, 0, 0, 1);
      cycle(1);
    end
    dec_valid_i = 0;
    reset = 1;
    cycle(0);
    reset = 0;
    check("reset_busy", dut.busy, 32'd0);
    check("reset_count", 32'(dut.count), 32'd0);
    set_dec(1, 3, 1, 31, 0, 0, 1);
    cycle(1);
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(99) == 0;
      set_dec($urandom_range(3) != 0, 3'($urandom_range(7)), 5'($urandom_range(7)),
              5'($urandom_range(7)), 5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      alu_ready_i = $urandom_range(3) != 0;
      mult_ready_i = $urandom_range(3) != 0;
      lsu_ready_i = $urandom_range(3) != 0;
      csr_ready_i = $urandom_range(3) != 0;
      wb_valid_i = 1'($urandom_range(1));
      wb_rd_i = 5'($urandom_range(7));
      resolve_valid_i = $urandom_range(3) == 0;
      flush_i = $urandom_range(29) == 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
